riscv_muldiv_issue_unit: RTL and testbench

Initiator side of the muldiv request/response protocol. Accepts mul/div/rem ops from the core's X stage, drives `muldivreq_*` into the pipelined mul/div unit, and tracks each in-flight op's destination register and result half in a tag FIFO. It also consumes `muldivresp_*`, extracts the correct 32-bit word, and presents a registered writeback beat to the W stage.

---
 rtl/riscv_muldiv_pkg.sv | 28 ++
 rtl/riscv_muldiv_tag_fifo.sv | 89 ++++++++
 rtl/riscv_muldiv_issue_unit.sv | 146 ++++++++++++++
 tb/tb_riscv_muldiv_issue_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_muldiv_pkg                                                     |
// | Shared tag layout and result-half decode for the muldiv issue path.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package riscv_muldiv_pkg;

  // Function codes follow the shared IMULDIV_MULDIVREQ_MSG_FUNC_* encoding.
  localparam logic [2:0] c_FN_REM  = 3'd3;
  localparam logic [2:0] c_FN_REMU = 3'd4;

  // One in-flight op: where the result goes and which half carries it.
  typedef struct packed {
    logic [4:0] rd;
    logic       hi_sel;
  } muldiv_tag_t;

  localparam int c_TAG_W = $bits(muldiv_tag_t);

  // Remainders live in the upper word of the responder result; everything
  // else (including unknown codes) uses the lower word.
  function automatic logic hi_sel_decode(input logic [2:0] fn);
    return (fn == c_FN_REM) || (fn == c_FN_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_muldiv_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_muldiv_tag_fifo                                                |
// | Synchronous FIFO holding tags of outstanding muldiv ops. Pointers    |
// | wrap modulo DEPTH, so DEPTH need not be a power of two.              |
// | RISCV_MULDIV_ISSUE_SCOREBOARD_EN exposes entry contents and validity.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module riscv_muldiv_tag_fifo
  import riscv_muldiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = c_TAG_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
  ,
  output logic [DEPTH*WIDTH-1:0]       entries,
  output logic [DEPTH-1:0]             entry_vld
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
  logic [31:0] w_rd_base;
  assign w_rd_base = 32'(r_rd_ptr);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] w_off;
    // Distance from the read pointer decides whether a slot is occupied.
    assign w_off = (32'(gi) >= w_rd_base) ? (32'(gi) - w_rd_base)
                                          : (32'(gi) + 32'(DEPTH) - w_rd_base);
    assign entry_vld[gi]               = (w_off < 32'(r_count));
    assign entries[gi*WIDTH +: WIDTH]  = r_mem[gi];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/riscv_muldiv_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_muldiv_issue_unit                                              |
// | Issues mul/div/rem requests to the pipelined muldiv responder under  |
// | credit control, tracks tags in order and returns a registered        |
// | writeback beat. RISCV_MULDIV_ISSUE_SCOREBOARD_EN adds busy_rd.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module riscv_muldiv_issue_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [2:0]                           issue_fn,
  input  logic [31:0]                          issue_a,
  input  logic [31:0]                          issue_b,
  input  logic [4:0]                           issue_rd,
  input  logic                                 issue_val,
  output logic                                 issue_rdy,
  output logic [2:0]                           muldivreq_msg_fn,
  output logic [31:0]                          muldivreq_msg_a,
  output logic [31:0]                          muldivreq_msg_b,
  output logic                                 muldivreq_val,
  input  logic                                 muldivreq_rdy,
  input  logic [63:0]                          muldivresp_msg_result,
  input  logic                                 muldivresp_val,
  output logic                                 muldivresp_rdy,
  output logic [31:0]                          wb_data,
  output logic [4:0]                           wb_rd,
  output logic                                 wb_val,
  input  logic                                 wb_rdy,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight_cnt,
  output logic                                 proto_err
`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
  ,
  output logic [31:0]                          busy_rd
`endif
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

  logic             w_credit_ok;
  logic             w_issue_fire;
  logic             w_resp_take;
  logic             w_resp_fire;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;
  muldiv_tag_t      w_push_tag;
  muldiv_tag_t      w_head_tag;

  logic             r_wb_val;
  logic [31:0]      r_wb_data;
  logic [4:0]       r_wb_rd;
  logic             r_proto_err;

`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
  logic [MAX_INFLIGHT*c_TAG_W-1:0] w_entries;
  logic [MAX_INFLIGHT-1:0]         w_entry_vld;
`endif

  // The FIFO is full exactly when MAX_INFLIGHT ops are outstanding, so
  // credit is simply "not full". A same-cycle response does not help.
  assign w_credit_ok      = !w_fifo_full;
  assign issue_rdy        = muldivreq_rdy && w_credit_ok;
  assign muldivreq_val    = issue_val && w_credit_ok;
  assign muldivreq_msg_fn = issue_fn;
  assign muldivreq_msg_a  = issue_a;
  assign muldivreq_msg_b  = issue_b;
  assign w_issue_fire     = issue_val && issue_rdy;

  // One-entry output stage: accept a response whenever the slot drains.
  assign muldivresp_rdy   = !r_wb_val || wb_rdy;
  assign w_resp_take      = muldivresp_val && muldivresp_rdy;
  assign w_resp_fire      = w_resp_take && !w_fifo_empty;

  assign w_push_tag       = '{rd: issue_rd, hi_sel: hi_sel_decode(issue_fn)};

  riscv_muldiv_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (c_TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_issue_fire),
    .push_data (w_push_tag),
    .pop       (w_resp_fire),
    .pop_data  (w_head_tag),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_count)
`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
    ,
    .entries   (w_entries),
    .entry_vld (w_entry_vld)
`endif
  );

  // Writeback register: load the tagged half on a response, drop on a beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_val  <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else if (w_resp_fire) begin
      r_wb_val  <= 1'b1;
      r_wb_data <= w_head_tag.hi_sel ? muldivresp_msg_result[63:32]
                                     : muldivresp_msg_result[31:0];
      r_wb_rd   <= w_head_tag.rd;
    end else if (r_wb_val && wb_rdy) begin
      r_wb_val  <= 1'b0;
    end
  end

  // Sticky error: a response was consumed with nothing outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_proto_err <= 1'b0;
    end else if (w_resp_take && w_fifo_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  assign wb_val       = r_wb_val;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign inflight_cnt = w_count;
  assign proto_err    = r_proto_err;

`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
  // Busy mask: OR of rd over every occupied tag slot plus the held beat.
  always_comb begin
    busy_rd = '0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      // rd occupies the upper five bits of each packed tag.
      if (w_entry_vld[i]) busy_rd[w_entries[i*c_TAG_W + 1 +: 5]] = 1'b1;
    end
    if (r_wb_val) busy_rd[r_wb_rd] = 1'b1;
    busy_rd[0] = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_issue_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_muldiv_issue_unit                                           |
// | Self-checking bench: behavioural 4-cycle responder plus an in-order  |
// | reference queue of expected writebacks. Honors                       |
// | RISCV_MULDIV_ISSUE_SCOREBOARD_EN for busy_rd.                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_riscv_muldiv_issue_unit;

  localparam int MAX = 4;
  localparam logic [2:0] F_MUL  = 3'd0;
  localparam logic [2:0] F_DIV  = 3'd1;
  localparam logic [2:0] F_DIVU = 3'd2;
  localparam logic [2:0] F_REM  = 3'd3;
  localparam logic [2:0] F_REMU = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  issue_fn;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic        issue_val, issue_rdy;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_val, wb_rdy;
  logic [2:0]  inflight_cnt;
  logic        proto_err;
`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
  logic [31:0] busy_rd;
`endif

  always #5 clk = ~clk;

  riscv_muldiv_issue_unit #(.MAX_INFLIGHT(MAX)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .issue_fn              (issue_fn),
    .issue_a               (issue_a),
    .issue_b               (issue_b),
    .issue_rd              (issue_rd),
    .issue_val             (issue_val),
    .issue_rdy             (issue_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_data               (wb_data),
    .wb_rd                 (wb_rd),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy),
    .inflight_cnt          (inflight_cnt),
    .proto_err             (proto_err)
`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
    ,
    .busy_rd               (busy_rd)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [63:0] res; int due; } rsp_t;
  wb_t  exp_q[$];
  rsp_t rsp_q[$];
  wb_t  held;
  int   cnt_m;
  bit   wbv_m, perr_m;
  int   cyc;
  bit   hold_resp, inject;

  // Architectural result of each op as seen by the register file.
  function automatic logic [31:0] op_word(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      F_MUL:   return a * b;
      F_DIV:   return $signed(a) / $signed(b);
      F_DIVU:  return a / b;
      F_REM:   return $signed(a) % $signed(b);
      F_REMU:  return a % b;
      default: return a ^ b;
    endcase
  endfunction

  // What the responder puts on the wire: {hi, lo}.
  function automatic logic [63:0] rsp_word(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (fn)
      F_MUL: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p;
      end
      F_DIV, F_REM:   return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      F_DIVU, F_REMU: return {a % b, a / b};
      default:        return {~a, a ^ b};
    endcase
  endfunction

  task automatic set_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    issue_fn = fn; issue_a = a; issue_b = b; issue_rd = rd;
  endtask

  task automatic rand_op();
    logic [31:0] b;
    b = $urandom;
    if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd7;
    set_op(3'($urandom_range(0, 7)), $urandom, b, 5'($urandom));
  endtask

  // One clock: drive responder, check at negedge, advance model, step edge.
  task automatic tick();
    bit iss, take, beat;
    logic [31:0] busy_m;
    if (inject) begin
      muldivresp_val = 1'b1; muldivresp_msg_result = {$urandom, $urandom};
    end else if (!hold_resp && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      muldivresp_val = 1'b1; muldivresp_msg_result = rsp_q[0].res;
    end else begin
      muldivresp_val = 1'b0; muldivresp_msg_result = '0;
    end
    @(negedge clk);
    check("issue_rdy", issue_rdy, muldivreq_rdy && (cnt_m < MAX));
    check("req_val", muldivreq_val, issue_val && (cnt_m < MAX));
    check("req_fn", muldivreq_msg_fn, issue_fn);
    check("req_ab", {muldivreq_msg_a, muldivreq_msg_b}, {issue_a, issue_b});
    check("resp_rdy", muldivresp_rdy, !wbv_m || wb_rdy);
    check("inflight", inflight_cnt, cnt_m);
    check("wb_val", wb_val, wbv_m);
    if (wbv_m) begin
      check("wb_data", wb_data, held.data);
      check("wb_rd", wb_rd, held.rd);
    end
    check("proto_err", proto_err, perr_m);
`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
    busy_m = '0;
    foreach (exp_q[i]) busy_m[exp_q[i].rd] = 1'b1;
    if (wbv_m) busy_m[held.rd] = 1'b1;
    busy_m[0] = 1'b0;
    check("busy_rd", busy_rd, busy_m);
`else
    busy_m = '0;
`endif
    iss  = issue_val && muldivreq_rdy && (cnt_m < MAX);
    take = muldivresp_val && (!wbv_m || wb_rdy);
    beat = wbv_m && wb_rdy;
    if (take) begin
      if (cnt_m == 0) perr_m = 1'b1;
      else begin held = exp_q.pop_front(); wbv_m = 1'b1; cnt_m--; end
      if (!inject && rsp_q.size() > 0) void'(rsp_q.pop_front());
    end else if (beat) begin
      wbv_m = 1'b0;
    end
    if (iss) begin
      exp_q.push_back('{issue_rd, op_word(issue_fn, issue_a, issue_b)});
      rsp_q.push_back('{rsp_word(issue_fn, issue_a, issue_b), cyc + 4});
      cnt_m++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    issue_val = 1'b0; wb_rdy = 1'b1; muldivreq_rdy = 1'b1; hold_resp = 1'b0;
    while ((cnt_m != 0 || wbv_m || rsp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 200, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; issue_val = 1'b0; set_op(3'd0, 32'd0, 32'd0, 5'd0);
    muldivreq_rdy = 1'b1; wb_rdy = 1'b1; muldivresp_val = 1'b0; muldivresp_msg_result = '0;
    hold_resp = 1'b0; inject = 1'b0; cyc = 0; cnt_m = 0; wbv_m = 1'b0; perr_m = 1'b0;
    held.rd = '0; held.data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_val", wb_val, 1'b0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_inflight", inflight_cnt, 3'd0);
    check("rst_proto_err", proto_err, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // MUL 3 * -5 -> rd 7, writeback five cycles after issue
    set_op(F_MUL, 32'd3, 32'hFFFF_FFFB, 5'd7); issue_val = 1'b1;
    #1 check("mul_req_val", muldivreq_val, 1'b1);
    tick(); issue_val = 1'b0;
    repeat (3) tick();
    check("mul_wb_early", wb_val, 1'b0);
    tick();
    check("mul_wb_val", wb_val, 1'b1);
    check("mul_wb_data", wb_data, 32'hFFFF_FFF1);
    check("mul_wb_rd", wb_rd, 5'd7);
    drain();

    // REMU then DIVU back to back
    set_op(F_REMU, 32'd17, 32'd5, 5'd3); issue_val = 1'b1; tick();
    set_op(F_DIVU, 32'd17, 32'd5, 5'd4); tick(); issue_val = 1'b0;
    repeat (3) tick();
    check("remu_wb_val", wb_val, 1'b1);
    check("remu_wb_data", wb_data, 32'd2);
    check("remu_wb_rd", wb_rd, 5'd3);
    tick();
    check("divu_wb_val", wb_val, 1'b1);
    check("divu_wb_data", wb_data, 32'd3);
    check("divu_wb_rd", wb_rd, 5'd4);
    drain();

    // Credit limit: four outstanding, fifth blocked until a response fires
    hold_resp = 1'b1; issue_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_op(); issue_rd = 5'(10 + k); tick();
    end
    set_op(F_MUL, 32'd2, 32'd3, 5'd20);
    #1;
    check("full_cnt", inflight_cnt, 3'd4);
    check("full_issue_rdy", issue_rdy, 1'b0);
    repeat (3) tick();
    hold_resp = 1'b0;
    check("full_same_cycle", issue_rdy, 1'b0);
    tick();
    check("credit_back", issue_rdy, 1'b1);
    tick(); issue_val = 1'b0;
    drain();

    // Writeback stall holds the result and back-pressures the responder
    set_op(F_MUL, 32'd6, 32'd7, 5'd9); issue_val = 1'b1; tick();
    set_op(F_DIV, 32'hFFFF_FFF0, 32'd3, 5'd11); tick(); issue_val = 1'b0;
    wb_rdy = 1'b0;
    repeat (6) tick();
    check("stall_resp_rdy", muldivresp_rdy, 1'b0);
    check("stall_wb_val", wb_val, 1'b1);
    check("stall_wb_data", wb_data, 32'd42);
    wb_rdy = 1'b1;
    tick();
    tick();
    check("stall_second_data", wb_data, 32'hFFFF_FFFB);
    drain();

`ifdef RISCV_MULDIV_ISSUE_SCOREBOARD_EN
    // Duplicate rd tracked per entry; rd 0 never marked
    issue_val = 1'b1;
    set_op(F_MUL, 32'd1, 32'd1, 5'd5); tick();
    set_op(F_MUL, 32'd2, 32'd2, 5'd5); tick();
    set_op(F_MUL, 32'd3, 32'd3, 5'd0); tick();
    issue_val = 1'b0;
    check("sb_busy5", busy_rd[5], 1'b1);
    check("sb_busy0", busy_rd[0], 1'b0);
    drain();
    check("sb_idle", busy_rd, 32'd0);
`endif

    // Response with nothing outstanding
    inject = 1'b1; tick(); inject = 1'b0;
    check("perr_set", proto_err, 1'b1);
    check("perr_no_wb", wb_val, 1'b0);
    repeat (2) tick();

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      issue_val     = ($urandom_range(0, 9) < 7);
      rand_op();
      muldivreq_rdy = ($urandom_range(0, 9) < 9);
      wb_rdy        = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Asynchronous reset in the middle of traffic
    #2 reset = 1'b0;
    #1;
    check("arst_wb_val", wb_val, 1'b0);
    check("arst_wb_data", wb_data, 32'd0);
    check("arst_wb_rd", wb_rd, 5'd0);
    check("arst_inflight", inflight_cnt, 3'd0);
    check("arst_proto_err", proto_err, 1'b0);
    exp_q.delete(); rsp_q.delete();
    cnt_m = 0; wbv_m = 1'b0; perr_m = 1'b0;
    issue_val = 1'b0; muldivresp_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    for (int k = 0; k < 300; k++) begin
      issue_val     = ($urandom_range(0, 9) < 8);
      rand_op();
      muldivreq_rdy = ($urandom_range(0, 9) < 8);
      wb_rdy        = ($urandom_range(0, 4) != 0);
      tick();
    end
    drain();
    check("end_exp_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
